// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between the icache (read-only) and the
// dcache (read/write). One transaction is in flight at a time. The dcache
// wins by default, and an aging counter stops the icache from starving.
module mem_arbiter #(
   parameter int STARVE_MAX = 4,
   parameter int CNT_W      = 4
) (
   input  logic        CLK,
   input  logic        RST,
   // icache side
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic [31:0] iload,
   output logic        iwait,
   // dcache side
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic [31:0] dload,
   output logic        dwait,
   // RAM side
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic [1:0]  ramstate,
   // state visibility
   output logic [1:0]  grant
);

   localparam logic [1:0] RAM_ACCESS = 2'd2;

   localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(STARVE_MAX);
   localparam logic [CNT_W-1:0] CNT_SAT      = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISERV = 2'd1,
      DSERV = 2'd2
   } state_t;

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  starve_cnt_reg, starve_cnt_next;
   logic              ram_access;

   // ERROR, FREE and BUSY all mean "not done yet"; only ACCESS completes.
   assign ram_access = (ramstate == RAM_ACCESS);

   // Read data is a plain pass-through; the waits qualify it.
   assign iload = ramload;
   assign dload = ramload;

   // Next-state selection: aged icache first, then dcache, then icache.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (iREN && (starve_cnt_reg >= STARVE_LIMIT))
               state_next = ISERV;
            else if (dREN || dWEN)
               state_next = DSERV;
            else if (iREN)
               state_next = ISERV;
         end
         ISERV: begin
            // Completion or abandonment both return to IDLE.
            if (ram_access || !iREN)
               state_next = IDLE;
         end
         DSERV: begin
            if (ram_access || (!dREN && !dWEN))
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Starvation age: counts ungranted icache cycles, cleared once served
   // or once the icache stops asking.
   always_comb begin
      starve_cnt_next = starve_cnt_reg;
      if (!iREN || (state_reg == ISERV))
         starve_cnt_next = '0;
      else if (starve_cnt_reg != CNT_SAT)
         starve_cnt_next = starve_cnt_reg + 1'b1;
   end

   // State and age registers; reset takes effect without waiting for a clock.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_reg      <= IDLE;
         starve_cnt_reg <= '0;
      end else begin
         state_reg      <= state_next;
         starve_cnt_reg <= starve_cnt_next;
      end
   end

   // Output decode from the registered state; request fields are forwarded
   // while granted so the cache drives the RAM directly.
   always_comb begin
      iwait    = 1'b1;
      dwait    = 1'b1;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      grant    = 2'd0;
      case (state_reg)
         ISERV: begin
            grant   = 2'd1;
            ramREN  = 1'b1;
            ramaddr = iaddr;
            iwait   = ~ram_access;
         end
         DSERV: begin
            grant    = 2'd2;
            ramaddr  = daddr;
            ramstore = dstore;
            // A write wins when both enables are high.
            ramWEN   = dWEN;
            ramREN   = ~dWEN;
            dwait    = ~ram_access;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: one task per scenario, each with its
// own hand-computed expectations.
module tb_mem_arbiter;

   logic        CLK = 1'b0;
   logic        RST;
   logic        iREN;
   logic [31:0] iaddr;
   logic [31:0] iload;
   logic        iwait;
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic [31:0] dload;
   logic        dwait;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   logic [1:0]  ramstate;
   logic [1:0]  grant;

   int n_vec = 0;
   int n_err = 0;

   localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

   mem_arbiter #(.STARVE_MAX(4), .CNT_W(4)) dut (
      .CLK(CLK), .RST(RST),
      .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dload(dload), .dwait(dwait),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
      .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
      .grant(grant)
   );

   always #5 CLK = ~CLK;

   // Advance one rising edge and settle 1 time unit past it.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      iREN = 0; dREN = 0; dWEN = 0;
      iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0;
      ramload = 32'h5555_AAAA; ramstate = FREE;
      step(); step();
      n_vec++; if (grant !== 2'd0) begin n_err++; $display("FAIL reset_grant got %0d want 0", grant); end
      n_vec++; if ({iwait, dwait} !== 2'b11) begin n_err++; $display("FAIL reset_waits got %b want 11", {iwait, dwait}); end
      n_vec++; if ({ramREN, ramWEN} !== 2'b00) begin n_err++; $display("FAIL reset_enables got %b want 00", {ramREN, ramWEN}); end
      n_vec++; if (ramaddr !== 32'h0 || ramstore !== 32'h0) begin n_err++; $display("FAIL reset_addr_store got %h/%h want 0/0", ramaddr, ramstore); end
      n_vec++; if (iload !== 32'h5555_AAAA || dload !== 32'h5555_AAAA) begin n_err++; $display("FAIL reset_loads got %h/%h want 5555aaaa", iload, dload); end
      RST = 1'b0;
      step();
      n_vec++; if (grant !== 2'd0) begin n_err++; $display("FAIL idle_after_reset got %0d want 0", grant); end
      $display("test_reset done");
   endtask

   task automatic test_icache_read();
      iREN = 1; iaddr = 32'h40; ramstate = BUSY; ramload = 32'h0;
      step();  // ISERV, first BUSY cycle
      n_vec++; if (grant !== 2'd1) begin n_err++; $display("FAIL iread_grant got %0d want 1", grant); end
      n_vec++; if (ramREN !== 1'b1 || ramWEN !== 1'b0) begin n_err++; $display("FAIL iread_enables got %b%b want 10", ramREN, ramWEN); end
      n_vec++; if (ramaddr !== 32'h40) begin n_err++; $display("FAIL iread_addr got %h want 00000040", ramaddr); end
      n_vec++; if (iwait !== 1'b1) begin n_err++; $display("FAIL iread_busy1_iwait got %b want 1", iwait); end
      step();  // second BUSY cycle
      n_vec++; if (iwait !== 1'b1 || ramREN !== 1'b1) begin n_err++; $display("FAIL iread_busy2 got iwait=%b ren=%b want 1/1", iwait, ramREN); end
      step();
      ramstate = ACCESS; ramload = 32'hDEAD_BEEF;
      #1;
      n_vec++; if (iwait !== 1'b0) begin n_err++; $display("FAIL iread_access_iwait got %b want 0", iwait); end
      n_vec++; if (iload !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL iread_iload got %h want deadbeef", iload); end
      n_vec++; if (dwait !== 1'b1) begin n_err++; $display("FAIL iread_dwait got %b want 1", dwait); end
      iREN = 0;
      step();
      ramstate = FREE;
      #1;
      n_vec++; if (grant !== 2'd0 || ramREN !== 1'b0 || iwait !== 1'b1) begin n_err++; $display("FAIL iread_return_idle got g=%0d ren=%b iw=%b want 0/0/1", grant, ramREN, iwait); end
      $display("test_icache_read done");
   endtask

   task automatic test_simultaneous();
      iREN = 1; iaddr = 32'h44; dREN = 1; daddr = 32'h200; ramstate = BUSY;
      step();
      n_vec++; if (grant !== 2'd2) begin n_err++; $display("FAIL simul_first_grant got %0d want 2", grant); end
      n_vec++; if (ramaddr !== 32'h200 || ramREN !== 1'b1 || ramWEN !== 1'b0) begin n_err++; $display("FAIL simul_dread_drive got a=%h ren=%b wen=%b want 200/1/0", ramaddr, ramREN, ramWEN); end
      n_vec++; if (iwait !== 1'b1 || dwait !== 1'b1) begin n_err++; $display("FAIL simul_busy_waits got %b%b want 11", iwait, dwait); end
      ramstate = ACCESS;
      #1;
      n_vec++; if (dwait !== 1'b0 || iwait !== 1'b1) begin n_err++; $display("FAIL simul_daccess got dw=%b iw=%b want 0/1", dwait, iwait); end
      dREN = 0;
      step();
      ramstate = BUSY;
      #1;
      n_vec++; if (grant !== 2'd0) begin n_err++; $display("FAIL simul_gap_idle got %0d want 0", grant); end
      step();
      n_vec++; if (grant !== 2'd1 || ramaddr !== 32'h44) begin n_err++; $display("FAIL simul_then_icache got g=%0d a=%h want 1/44", grant, ramaddr); end
      ramstate = ACCESS;
      #1;
      n_vec++; if (iwait !== 1'b0) begin n_err++; $display("FAIL simul_iaccess got %b want 0", iwait); end
      iREN = 0;
      step();
      ramstate = FREE;
      $display("test_simultaneous done");
   endtask

   task automatic test_write_precedence();
      dREN = 1; dWEN = 1; daddr = 32'h100; dstore = 32'h1234_5678; ramstate = BUSY;
      step();
      n_vec++; if (grant !== 2'd2) begin n_err++; $display("FAIL wr_grant got %0d want 2", grant); end
      n_vec++; if (ramWEN !== 1'b1 || ramREN !== 1'b0) begin n_err++; $display("FAIL wr_enables got wen=%b ren=%b want 1/0", ramWEN, ramREN); end
      n_vec++; if (ramstore !== 32'h1234_5678 || ramaddr !== 32'h100) begin n_err++; $display("FAIL wr_data got %h@%h want 12345678@100", ramstore, ramaddr); end
      n_vec++; if (dwait !== 1'b1) begin n_err++; $display("FAIL wr_busy_dwait got %b want 1", dwait); end
      ramstate = ACCESS;
      #1;
      n_vec++; if (dwait !== 1'b0) begin n_err++; $display("FAIL wr_access_dwait got %b want 0", dwait); end
      dREN = 0; dWEN = 0;
      step();
      ramstate = FREE;
      #1;
      n_vec++; if (grant !== 2'd0 || ramWEN !== 1'b0) begin n_err++; $display("FAIL wr_return_idle got g=%0d wen=%b want 0/0", grant, ramWEN); end
      $display("test_write_precedence done");
   endtask

   task automatic test_error_retry();
      dREN = 1; daddr = 32'h300; ramstate = ERROR;
      step();
      for (int k = 0; k < 3; k++) begin
         n_vec++;
         if (grant !== 2'd2 || ramREN !== 1'b1 || ramaddr !== 32'h300 || dwait !== 1'b1) begin
            n_err++;
            $display("FAIL err_hold%0d got g=%0d ren=%b a=%h dw=%b want 2/1/300/1", k, grant, ramREN, ramaddr, dwait);
         end
         if (k < 2) step();
      end
      step();
      ramstate = ACCESS;
      #1;
      n_vec++; if (dwait !== 1'b0 || grant !== 2'd2) begin n_err++; $display("FAIL err_then_access got dw=%b g=%0d want 0/2", dwait, grant); end
      dREN = 0;
      step();
      ramstate = FREE;
      $display("test_error_retry done");
   endtask

   task automatic test_abort();
      iREN = 1; iaddr = 32'h80; ramstate = BUSY;
      step();
      n_vec++; if (grant !== 2'd1 || iwait !== 1'b1) begin n_err++; $display("FAIL abort_start got g=%0d iw=%b want 1/1", grant, iwait); end
      iREN = 0;
      #1;
      n_vec++; if (iwait !== 1'b1) begin n_err++; $display("FAIL abort_drop_iwait got %b want 1", iwait); end
      step();
      n_vec++; if (grant !== 2'd0 || iwait !== 1'b1 || ramREN !== 1'b0) begin n_err++; $display("FAIL abort_idle got g=%0d iw=%b ren=%b want 0/1/0", grant, iwait, ramREN); end
      ramstate = FREE;
      $display("test_abort done");
   endtask

   task automatic test_starvation();
      logic [1:0] exp_grant [7];
      exp_grant = '{2'd2, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd2};
      iREN = 1; iaddr = 32'h500; dREN = 1; daddr = 32'h600; ramstate = ACCESS;
      for (int k = 0; k < 7; k++) begin
         step();
         n_vec++;
         if (grant !== exp_grant[k]) begin
            n_err++;
            $display("FAIL starve_cycle%0d got grant %0d want %0d", k, grant, exp_grant[k]);
         end
         if (k == 4) begin
            n_vec++; if (iwait !== 1'b0 || ramaddr !== 32'h500 || dwait !== 1'b1) begin n_err++; $display("FAIL starve_iserv got iw=%b a=%h dw=%b want 0/500/1", iwait, ramaddr, dwait); end
         end
      end
      iREN = 0; dREN = 0;
      step();
      ramstate = FREE;
      #1;
      n_vec++; if (grant !== 2'd0) begin n_err++; $display("FAIL starve_end_idle got %0d want 0", grant); end
      $display("test_starvation done");
   endtask

   task automatic test_reset_mid_dserv();
      dWEN = 1; daddr = 32'h700; dstore = 32'hCAFE_F00D; ramstate = BUSY;
      step();
      n_vec++; if (ramWEN !== 1'b1 || grant !== 2'd2) begin n_err++; $display("FAIL rstmid_pre got wen=%b g=%0d want 1/2", ramWEN, grant); end
      #2 RST = 1'b1;
      #1;
      n_vec++; if (ramWEN !== 1'b0 || dwait !== 1'b1 || grant !== 2'd0) begin n_err++; $display("FAIL rstmid_async got wen=%b dw=%b g=%0d want 0/1/0", ramWEN, dwait, grant); end
      n_vec++; if (ramaddr !== 32'h0 || ramstore !== 32'h0) begin n_err++; $display("FAIL rstmid_bus got %h/%h want 0/0", ramaddr, ramstore); end
      dWEN = 0; ramstate = FREE;
      step();
      RST = 1'b0;
      step();
      n_vec++; if (grant !== 2'd0 || ramWEN !== 1'b0) begin n_err++; $display("FAIL rstmid_after got g=%0d wen=%b want 0/0", grant, ramWEN); end
      $display("test_reset_mid_dserv done");
   endtask

   initial begin
      test_reset();
      test_icache_read();
      test_simultaneous();
      test_write_precedence();
      test_error_retry();
      test_abort();
      test_starvation();
      test_reset_mid_dserv();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single RAM port between the instruction cache (read-only) and the data cache (read/write).
- One transaction is in flight at a time.
- Data-cache requests win by default. An aging counter guarantees instruction fetches are not starved.
- Sits between the two cache controllers and the RAM model; it presents the cache-side iwait/dwait handshake and the RAM-side REN/WEN/ramstate handshake.

Parameters:
- STARVE_MAX, 4: consecutive cycles iREN may be pending and ungranted before the icache is forced to win the next arbitration (legal range 1..15).
- CNT_W, 4: width of the starvation counter; must satisfy 2^CNT_W > STARVE_MAX.

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  asynchronous reset, active-high
- iREN  input  1  icache read request
- iaddr  input  32  icache word address
- iload  output  32  instruction data to icache
- iwait  output  1  0 = icache transaction completes this cycle
- dREN  input  1  dcache read request
- dWEN  input  1  dcache write request
- daddr  input  32  dcache word address
- dstore  input  32  dcache write data
- dload  output  32  read data to dcache
- dwait  output  1  0 = dcache transaction completes this cycle
- ramREN  output  1  RAM read enable
- ramWEN  output  1  RAM write enable
- ramaddr  output  32  RAM address
- ramstore  output  32  RAM write data
- ramload  input  32  RAM read data
- ramstate  input  2  0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
- grant  output  2  0 none, 1 icache, 2 dcache (state visibility)

Behaviour:
Reset values (asserted asynchronously):
- State IDLE, starvation counter 0.
- iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, grant=0.
- iload and dload follow ramload at all times (combinational pass-through); their value is meaningful only when the matching wait is 0.

States IDLE, ISERV, DSERV (registered):
- IDLE:
  - No RAM enables; both waits 1.
  - If iREN=1 and counter>=STARVE_MAX, go to ISERV.
  - Else if dREN or dWEN, go to DSERV.
  - Else if iREN, go to ISERV.
  - Else stay in IDLE.
- ISERV:
  - grant=1, ramREN=1, ramaddr=iaddr.
  - iwait = ~(ramstate==ACCESS).
  - On ACCESS, go to IDLE.
  - If iREN drops before ACCESS, go to IDLE next cycle with no iwait low pulse.
- DSERV:
  - grant=2, ramaddr=daddr, ramstore=dstore.
  - If dWEN=1: ramWEN=1, ramREN=0. Write has precedence when dREN and dWEN are both high.
  - Otherwise ramREN=1.
  - dwait = ~(ramstate==ACCESS); on ACCESS, go to IDLE.
  - If both dREN and dWEN drop before ACCESS, go to IDLE.
- RAM state handling in ISERV/DSERV:
  - FREE or BUSY: keep driving, wait stays 1.
  - ERROR: keep driving unchanged (retry), wait stays 1, no state change.

Latency and timing:
- A request first seen in IDLE at cycle N drives the RAM at N+1. The earliest wait-low is N+1, when RAM returns ACCESS immediately.
- After every completion there is one IDLE cycle before the next grant.
- Request inputs are combinationally forwarded while granted; caches hold address and data stable until wait=0.
- The non-granted requester always sees wait=1.

Starvation counter:
- Each cycle iREN=1 and grant!=1, counter increments, saturating at 2^CNT_W-1.
- Cleared on any cycle in ISERV, and on any cycle iREN=0.

Reset mid-transaction: immediate return to the reset values above. No completion is signalled and the RAM enables drop asynchronously.

Test Plan:
- Icache read: reset, iREN=1 iaddr=0x40, RAM BUSY 2 cycles then ACCESS with ramload=0xDEADBEEF -> ramREN=1 ramaddr=0x40 from cycle 1; iwait=0 and iload=0xDEADBEEF on the ACCESS cycle only; grant returns to 0 the next cycle.
- Simultaneous requests: iREN and dREN rise together, counter 0 -> DSERV first (grant=2); ISERV follows after a single IDLE cycle; iwait stays 1 throughout DSERV.
- Write precedence: dREN=dWEN=1, daddr=0x100, dstore=0x12345678 -> ramWEN=1, ramREN=0, ramstore=0x12345678; dwait=0 on ACCESS.
- Starvation: iREN held high while dREN is re-asserted back-to-back, STARVE_MAX=4 -> icache granted at the first IDLE after the counter reaches 4, even though dREN=1; counter reads 0 after the grant.
- ERROR and abort: ramstate=ERROR for 3 cycles then ACCESS -> enables held, wait=1 until ACCESS. Separately, iREN dropped mid-ISERV -> IDLE next cycle, iwait never 0.
- Reset mid-DSERV: RST pulsed while ramWEN=1 -> ramWEN=0, dwait=1, grant=0 immediately (same cycle, not on the next clock edge).
